// File: rtl/palette_mapper.sv
// palette_mapper: maps object-hit flags plus a colour-mode select to an RGB
// word through a writable palette RAM. Two-stage pixel pipeline, self-filling
// mono palette after reset, run-time write port for the control/OSD logic.
// Optional second read port for palette readback: PALETTE_MAPPER_READBACK_EN.
module palette_mapper #(
  parameter int NUM_OBJ = 4,
  parameter int MODE_W  = 4,
  parameter int BPC     = 4,
  parameter int SLOT_W  = 3
) (
  input  logic                      clkvideo,
  input  logic                      reset,
  input  logic                      hsync,
  input  logic [NUM_OBJ-1:0]        vincomp,
  input  logic [MODE_W-1:0]         vmode,
  input  logic                      pal_we,
  input  logic [MODE_W+SLOT_W-1:0]  pal_addr,
  input  logic [3*BPC-1:0]          pal_wdata,
  output logic                      pal_ready,
  output logic                      hsync_out,
  output logic [3*BPC-1:0]          voutrgb
`ifdef PALETTE_MAPPER_READBACK_EN
  ,
  input  logic                      pal_re,
  output logic [3*BPC-1:0]          pal_rdata
`endif
);

  localparam int AW    = MODE_W + SLOT_W;
  localparam int DEPTH = 1 << AW;
  localparam int DW    = 3 * BPC;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_nx;
  logic [AW-1:0]     init_cnt;
  logic [DW-1:0]     mem [DEPTH];

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [SLOT_W-1:0] slot;

  logic [AW-1:0]     s1_addr;
  logic              s1_hs;
  logic [DW-1:0]     ram_q;
  logic              s2_hs;

  // State register and init sweep counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clkvideo) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  // Next-state: leave INIT once the last address has been written.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    if (state == INIT && init_cnt == '1) state_nx = RUN;
  end

  assign pal_ready = (state == RUN);

  // Write-port mux: init sweep owns the RAM until RUN; user writes need pal_ready.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = pal_addr;
    wr_data = pal_wdata;
    if (state == INIT) begin
      wr_en   = 1'b1;
      wr_addr = init_cnt;
      wr_data = (init_cnt[SLOT_W-1:0] == '0) ? '0 : '1;
    end else if (pal_we) begin
      wr_en = 1'b1;
    end
  end

  // Fixed-priority slot encode: lowest set object bit wins, slot 0 if none.
  always_comb begin
    slot = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (vincomp[i]) slot = SLOT_W'(i + 1);
    end
  end

  // Palette RAM write port.
  // NOTE: the RAM array itself has no reset; the INIT sweep fills every entry.
  always_ff @(posedge clkvideo) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Pixel pipeline: stage 1 address/hsync, stage 2 read-first RAM data/hsync.
  always_ff @(posedge clkvideo) begin
    if (reset) begin
      s1_addr <= '0;
      s1_hs   <= 1'b0;
      ram_q   <= '0;
      s2_hs   <= 1'b0;
    end else begin
      s1_addr <= {vmode, slot};
      s1_hs   <= hsync;
      ram_q   <= mem[s1_addr];
      s2_hs   <= s1_hs;
    end
  end

  assign hsync_out = s2_hs;
  assign voutrgb   = (s2_hs || !pal_ready) ? '0 : ram_q;

`ifdef PALETTE_MAPPER_READBACK_EN
  // Readback port: one-cycle read of pal_addr, holds when idle, 0 before RUN.
  always_ff @(posedge clkvideo) begin
    if (reset) begin
      pal_rdata <= '0;
    end else if (pal_re) begin
      pal_rdata <= pal_ready ? mem[pal_addr] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_palette_mapper.sv
// Scoreboard bench for palette_mapper: directed pixels push hand-computed
// expected colours into a queue; a monitor pops and compares two clocks later.
module tb_palette_mapper;

  logic        clkvideo = 1'b0;
  logic        reset    = 1'b1;
  logic        hsync    = 1'b0;
  logic [3:0]  vincomp  = '0;
  logic [3:0]  vmode    = '0;
  logic        pal_we   = 1'b0;
  logic [6:0]  pal_addr = '0;
  logic [11:0] pal_wdata = '0;
  logic        pal_ready;
  logic        hsync_out;
  logic [11:0] voutrgb;
`ifdef PALETTE_MAPPER_READBACK_EN
  logic        pal_re = 1'b0;
  logic [11:0] pal_rdata;
`endif

  palette_mapper dut (
    .clkvideo (clkvideo),
    .reset    (reset),
    .hsync    (hsync),
    .vincomp  (vincomp),
    .vmode    (vmode),
    .pal_we   (pal_we),
    .pal_addr (pal_addr),
    .pal_wdata(pal_wdata),
    .pal_ready(pal_ready),
    .hsync_out(hsync_out),
    .voutrgb  (voutrgb)
`ifdef PALETTE_MAPPER_READBACK_EN
    ,
    .pal_re   (pal_re),
    .pal_rdata(pal_rdata)
`endif
  );

  always #5 clkvideo = ~clkvideo;

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic pix_vld = 1'b0;
  logic [1:0] vld_d = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Bench-side valid pipeline marking which cycles carry an issued pixel.
  always @(posedge clkvideo) vld_d <= {vld_d[0], pix_vld};

  // Monitor: compare the DUT output against the oldest expected pixel.
  always @(negedge clkvideo) begin
    if (vld_d[1]) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon_underflow: got empty queue required entry at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pix_rgb", {20'd0, voutrgb}, {20'd0, e.rgb});
        check("pix_hs", {31'd0, hsync_out}, {31'd0, e.hs});
      end
    end
  end

  // Issue one pixel (and optional write) at a negedge; advance one clock.
  task automatic pix(input logic [3:0] m, input logic [3:0] vin, input logic hs,
                     input logic we, input logic [6:0] wa, input logic [11:0] wd,
                     input logic [11:0] exp_rgb);
    exp_t e;
    vmode = m; vincomp = vin; hsync = hs;
    pal_we = we; pal_addr = wa; pal_wdata = wd;
    pix_vld = 1'b1;
    e.rgb = exp_rgb;
    e.hs  = hs;
    exp_q.push_back(e);
    @(posedge clkvideo);
    @(negedge clkvideo);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      vmode = '0; vincomp = '0; hsync = 1'b0;
      pal_we = 1'b0; pix_vld = 1'b0;
      @(posedge clkvideo);
      @(negedge clkvideo);
    end
  endtask

  task automatic do_reset();
    @(negedge clkvideo);
    reset = 1'b1;
    pal_we = 1'b0; pix_vld = 1'b0; hsync = 1'b0; vincomp = '0; vmode = '0;
    @(posedge clkvideo);
    @(negedge clkvideo);
    reset = 1'b0;
  endtask

  // Expect pal_ready low before each of 128 edges, high after the 128th.
  // Optionally attempt a write to {2,1} just before edge lock_at.
  task automatic init_check(input int lock_at);
    for (int i = 1; i <= 128; i++) begin
      check("init_ready_low", {31'd0, pal_ready}, 32'd0);
      check("init_rgb_zero", {20'd0, voutrgb}, 32'd0);
      if (i == 1) check("reset_hsync_out", {31'd0, hsync_out}, 32'd0);
      if (i == lock_at) begin
        pal_we = 1'b1; pal_addr = 7'h11; pal_wdata = 12'h123;
      end else begin
        pal_we = 1'b0;
      end
      @(posedge clkvideo);
      @(negedge clkvideo);
    end
    pal_we = 1'b0;
    check("init_ready_high", {31'd0, pal_ready}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    idle(3);
    while (exp_q.size() != 0 && n < 10) begin
      idle(1);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    // Init timing after the first reset.
    do_reset();
    init_check(0);

    // Default mono palette.
    pix(4'd3, 4'b0000, 1'b0, 1'b0, 7'h00, 12'h000, 12'h000);
    pix(4'd3, 4'b0100, 1'b0, 1'b0, 7'h00, 12'h000, 12'hFFF);
    pix(4'd15, 4'b1000, 1'b0, 1'b0, 7'h00, 12'h000, 12'hFFF);

    // Program {2,1} = F00 and {2,3} = 00F while showing bank 2 background.
    pix(4'd2, 4'b0000, 1'b0, 1'b1, 7'h11, 12'hF00, 12'h000);
    pix(4'd2, 4'b0000, 1'b0, 1'b1, 7'h13, 12'h00F, 12'h000);

    // Priority: object 0 beats object 2; object 2 alone selects slot 3.
    pix(4'd2, 4'b0101, 1'b0, 1'b0, 7'h00, 12'h000, 12'hF00);
    pix(4'd2, 4'b0100, 1'b0, 1'b0, 7'h00, 12'h000, 12'h00F);

    // Blanking: three hsync pixels are black and carry hsync_out.
    pix(4'd2, 4'b0001, 1'b0, 1'b0, 7'h00, 12'h000, 12'hF00);
    pix(4'd2, 4'b0001, 1'b1, 1'b0, 7'h00, 12'h000, 12'h000);
    pix(4'd2, 4'b0001, 1'b1, 1'b0, 7'h00, 12'h000, 12'h000);
    pix(4'd2, 4'b0001, 1'b1, 1'b0, 7'h00, 12'h000, 12'h000);
    pix(4'd2, 4'b0001, 1'b0, 1'b0, 7'h00, 12'h000, 12'hF00);

    // Read-first: the write lands on the edge that reads the previous pixel
    // (shows old F00); pixels from the write cycle on show 0F4.
    pix(4'd2, 4'b0001, 1'b0, 1'b0, 7'h00, 12'h000, 12'hF00);
    pix(4'd2, 4'b0001, 1'b0, 1'b1, 7'h11, 12'h0F4, 12'h0F4);
    pix(4'd2, 4'b0001, 1'b0, 1'b0, 7'h00, 12'h000, 12'h0F4);
    drain();

    // Reset in RUN, then reset again at init count 50; write attempted in INIT.
    do_reset();
    for (int i = 0; i < 50; i++) @(posedge clkvideo);
    do_reset();
    init_check(100);

    // User entries overwritten by re-init; locked-out write dropped.
    pix(4'd2, 4'b0001, 1'b0, 1'b0, 7'h00, 12'h000, 12'hFFF);
    pix(4'd2, 4'b0100, 1'b0, 1'b0, 7'h00, 12'h000, 12'hFFF);
    pix(4'd0, 4'b0000, 1'b0, 1'b0, 7'h00, 12'h000, 12'h000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
